hazard_scoreboard_unit: RTL and testbench
=========================================

// Module: hazard_scoreboard_unit
// PURPOSE
//  Parametrised forwarding/interlock unit for the 5-stage MIPS pipeline, sitting beside the DE stage.
//  Generalises single EXE/MEM forwarding and load-use stall to NUM_SRC read ports and NUM_FWD bypass stages.
//  Adds a per-register pending scoreboard for long-latency producers (multi-cycle loads, mul/div).
//  Adds a saturating stall-cycle counter for performance reporting.
// PARAMETERS
//  DATA_W   32  register data width
//  REG_AW   5   register address width; 2**REG_AW scoreboard entries
//  NUM_SRC  2   source operands per DE instruction (rs, rt)
//  NUM_FWD  3   bypass stages; index 0 = youngest (EXE), then MEM, then WB
//  CNT_W    16  stall counter width
// PORTS
//  clk          in   1                 clock
//  resetn       in   1                 synchronous reset, active low
//  src_addr     in   NUM_SRC*REG_AW    DE source register numbers; lane i at [i*REG_AW +: REG_AW]
//  src_used     in   NUM_SRC           1 = the instruction actually reads lane i
//  src_rdata    in   NUM_SRC*DATA_W    register-file read data, per lane
//  fwd_wen      in   NUM_FWD           stage j holds a valid GPR-writing instruction
//  fwd_addr     in   NUM_FWD*REG_AW    stage j destination register
//  fwd_ready    in   NUM_FWD           stage j result value is available this cycle
//  fwd_data     in   NUM_FWD*DATA_W    stage j result value
//  issue_valid  in   1                 DE instruction leaves DE this cycle
//  issue_long   in   1                 the issuing instruction is a long-latency producer
//  issue_dest   in   REG_AW            destination register of the issuing instruction
//  cmpl_valid   in   1                 a long-latency producer writes back this cycle
//  cmpl_dest    in   REG_AW            destination register of the completing producer
//  flush        in   1                 exception/eret flush; kills all in-flight instructions
//  src_data     out  NUM_SRC*DATA_W    operand data after forwarding, per lane
//  stall        out  1                 hold DE (and IF) this cycle
//  sb_busy      out  1                 at least one scoreboard bit is set
//  stall_cnt    out  CNT_W             total cycles with stall=1
// BEHAVIOUR
//  Reset (resetn=0 at posedge): pending[] <= 0, stall_cnt <= 0. sb_busy is 0 in the following cycle.
//  Forward hit, lane i / stage j: fwd_wen[j] & src_used[i] & fwd_addr[j]==src_addr[i] & src_addr[i]!=0.
//  Priority: the lowest j that hits wins; src_data = fwd_data[j]. With no hit, src_data = src_rdata. Combinational, 0 latency.
//  Winning hit with fwd_ready[j]=0: the lane is not ready. Older stages are NOT consulted (stale-value rule).
//  Scoreboard hit, lane i: src_used[i] & src_addr[i]!=0 & pending[src_addr[i]].
//   - Cleared by a same-cycle completion: cmpl_valid & cmpl_dest==src_addr[i] bypasses the bit.
//   - The completing stage must also present its value on a fwd entry.
//  stall = OR over lanes of (not-ready forward hit | uncleared scoreboard hit). Combinational.
//  Gated issue: issue_eff = issue_valid & ~stall & ~flush. The block ignores issue_valid while stalled.
//  Pending update at posedge, in priority order:
//   - flush=1: all bits <= 0. Any completion or issue in that cycle is discarded.
//   - else, cmpl_valid: pending[cmpl_dest] <= 0.
//   - then, issue_eff & issue_long & issue_dest!=0: pending[issue_dest] <= 1.
//     Set wins over clear on the same register (a new producer overrides the completing one).
//   - pending[0] is never set.
//  cmpl_valid on a register that is not pending: no effect, no error.
//  stall_cnt: +1 every cycle with stall=1 (including flush cycles). Saturates at all-ones and holds.
//  sb_busy = |pending (registered state only; ignores same-cycle completion).
//  Reset mid-operation: pending state is lost. Upstream pipeline reset guarantees no stale cmpl arrives.
// STRUCTURE
//  Shared header hazard_defs.vh:
//   - stage index constants FWD_EXE=0, FWD_MEM=1, FWD_WB=2
//   - default REG_AW/DATA_W
//  Sub-module fwd_lane_mux (one per source lane, generate loop):
//   - inputs: one lane's addr/used/rdata plus the full fwd bus
//   - outputs: lane data and lane not-ready flag
//  Top level holds the pending register, update priority logic, stall OR-reduction and stall counter.
// TESTING
//  1. EXE wen,addr=8,ready=1,data=0xAAAA; MEM addr=8,data=0xBBBB; src0=8 used -> src_data0=0xAAAA, stall=0.
//  2. EXE addr=9,ready=0 (load); MEM addr=9,ready=1; src1=9 used -> stall=1; same with src_used[1]=0 -> stall=0, src_data1=src_rdata1.
//  3. Issue long dest=5; next cycle src0=5 -> stall=1, sb_busy=1; cmpl dest=5 + WB fwd 5 data=0x1234 -> stall=0, src_data0=0x1234; next cycle sb_busy=0.
//  4. pending[5] set; same cycle cmpl dest=5 and issue long dest=5 -> pending[5] stays 1; src0=5 then stalls.
//  5. pending{3,7} set; flush=1 with issue_valid=1,long,dest=4 -> next cycle sb_busy=0, no stall on 3/4/7.
//  6. CNT_W=4: hold stall for 20 cycles -> stall_cnt=15 and holds; resetn=0 one cycle -> stall_cnt=0, sb_busy=0; src_addr=0 never stalls.

Source files
------------

// File: rtl/hazard_scoreboard_unit_pkg.sv
// rtl/hazard_scoreboard_unit_pkg.sv - shared constants for the hazard/forwarding unit
package hazard_scoreboard_unit_pkg;

  localparam int FWD_EXE = 0;
  localparam int FWD_MEM = 1;
  localparam int FWD_WB  = 2;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_REG_AW  = 5;
  localparam int DEF_NUM_SRC = 2;
  localparam int DEF_NUM_FWD = FWD_WB + 1;
  localparam int DEF_CNT_W   = 16;

endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// rtl/hazard_scoreboard_unit_if.sv - operand, bypass, issue and status bus of the hazard unit
interface hazard_scoreboard_unit_if
  import hazard_scoreboard_unit_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int REG_AW  = DEF_REG_AW,
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int NUM_FWD = DEF_NUM_FWD,
  parameter int CNT_W   = DEF_CNT_W
);
  logic [NUM_SRC*REG_AW-1:0] src_addr;
  logic [NUM_SRC-1:0]        src_used;
  logic [NUM_SRC*DATA_W-1:0] src_rdata;
  logic [NUM_FWD-1:0]        fwd_wen;
  logic [NUM_FWD*REG_AW-1:0] fwd_addr;
  logic [NUM_FWD-1:0]        fwd_ready;
  logic [NUM_FWD*DATA_W-1:0] fwd_data;
  logic                      issue_valid;
  logic                      issue_long;
  logic [REG_AW-1:0]         issue_dest;
  logic                      cmpl_valid;
  logic [REG_AW-1:0]         cmpl_dest;
  logic                      flush;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic                      stall;
  logic                      sb_busy;
  logic [CNT_W-1:0]          stall_cnt;

  modport master (
    output src_addr, src_used, src_rdata, fwd_wen, fwd_addr, fwd_ready, fwd_data,
           issue_valid, issue_long, issue_dest, cmpl_valid, cmpl_dest, flush,
    input  src_data, stall, sb_busy, stall_cnt
  );

  modport slave (
    input  src_addr, src_used, src_rdata, fwd_wen, fwd_addr, fwd_ready, fwd_data,
           issue_valid, issue_long, issue_dest, cmpl_valid, cmpl_dest, flush,
    output src_data, stall, sb_busy, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard_unit_fwd_lane_mux.sv
// rtl/hazard_scoreboard_unit_fwd_lane_mux.sv - per-lane bypass select with youngest-stage priority
module fwd_lane_mux
  import hazard_scoreboard_unit_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int REG_AW  = DEF_REG_AW,
  parameter int NUM_FWD = DEF_NUM_FWD
) (
  input  logic [REG_AW-1:0]         lane_addr,
  input  logic                      lane_used,
  input  logic [DATA_W-1:0]         lane_rdata,
  input  logic [NUM_FWD-1:0]        fwd_wen,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_addr,
  input  logic [NUM_FWD-1:0]        fwd_ready,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
  output logic [DATA_W-1:0]         lane_data,
  output logic                      lane_not_ready
);

  // Scan oldest to youngest so the youngest hit is the last write; its readiness
  // alone decides the lane, since an older stage's value would be stale.
  always_comb begin
    lane_data      = lane_rdata;
    lane_not_ready = 1'b0;
    for (int j = NUM_FWD - 1; j >= 0; j--) begin
      if (lane_used && (lane_addr != '0) && fwd_wen[j] &&
          (fwd_addr[j*REG_AW +: REG_AW] == lane_addr)) begin
        lane_data      = fwd_data[j*DATA_W +: DATA_W];
        lane_not_ready = ~fwd_ready[j];
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// rtl/hazard_scoreboard_unit.sv - DE-stage forwarding, load-use interlock and long-latency scoreboard
module hazard_scoreboard_unit
  import hazard_scoreboard_unit_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int REG_AW  = DEF_REG_AW,
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int NUM_FWD = DEF_NUM_FWD,
  parameter int CNT_W   = DEF_CNT_W
) (
  input logic                    clk,
  input logic                    resetn,
  hazard_scoreboard_unit_if.slave bus
);

  localparam int NREG = 2 ** REG_AW;

  logic [NREG-1:0]           pending_q, pending_d;
  logic [CNT_W-1:0]          stall_cnt_q, stall_cnt_d;
  logic [NUM_SRC-1:0]        lane_not_ready;
  logic [NUM_SRC-1:0]        lane_sb_hit;
  logic [NUM_SRC*DATA_W-1:0] lane_data;
  logic                      stall;
  logic                      issue_eff;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_lane
    fwd_lane_mux #(
      .DATA_W  (DATA_W),
      .REG_AW  (REG_AW),
      .NUM_FWD (NUM_FWD)
    ) u_mux (
      .lane_addr      (bus.src_addr[gi*REG_AW +: REG_AW]),
      .lane_used      (bus.src_used[gi]),
      .lane_rdata     (bus.src_rdata[gi*DATA_W +: DATA_W]),
      .fwd_wen        (bus.fwd_wen),
      .fwd_addr       (bus.fwd_addr),
      .fwd_ready      (bus.fwd_ready),
      .fwd_data       (bus.fwd_data),
      .lane_data      (lane_data[gi*DATA_W +: DATA_W]),
      .lane_not_ready (lane_not_ready[gi])
    );
  end

  // A completion in this very cycle releases the register even though its bit is still set.
  always_comb begin
    logic [REG_AW-1:0] a;
    a           = '0;
    lane_sb_hit = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      a = bus.src_addr[i*REG_AW +: REG_AW];
      lane_sb_hit[i] = bus.src_used[i] && (a != '0) && pending_q[a] &&
                       !(bus.cmpl_valid && (bus.cmpl_dest == a));
    end
  end

  assign stall     = |(lane_not_ready | lane_sb_hit);
  assign issue_eff = bus.issue_valid && !stall && !bus.flush;

  // Set after clear so a new producer overrides the one completing on the same register.
  always_comb begin
    pending_d = pending_q;
    if (bus.flush) begin
      pending_d = '0;
    end else begin
      if (bus.cmpl_valid) begin
        pending_d[bus.cmpl_dest] = 1'b0;
      end
      if (issue_eff && bus.issue_long && (bus.issue_dest != '0)) begin
        pending_d[bus.issue_dest] = 1'b1;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pending_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      pending_q   <= pending_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.src_data  = lane_data;
  assign bus.stall     = stall;
  assign bus.sb_busy   = |pending_q;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// tb/tb_hazard_scoreboard_unit.sv - directed and randomized bench against a register-level hazard model
module tb_hazard_scoreboard_unit;

  localparam int DATA_W  = 32;
  localparam int REG_AW  = 5;
  localparam int NUM_SRC = 2;
  localparam int NUM_FWD = 3;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  hazard_scoreboard_unit_if #(
    .DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .NUM_FWD(NUM_FWD), .CNT_W(CNT_W)
  ) bus ();

  hazard_scoreboard_unit #(
    .DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .NUM_FWD(NUM_FWD), .CNT_W(CNT_W)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  logic [REG_AW-1:0] s_addr  [NUM_SRC];
  logic              s_used  [NUM_SRC];
  logic [DATA_W-1:0] s_rdata [NUM_SRC];
  logic              f_wen   [NUM_FWD];
  logic [REG_AW-1:0] f_addr  [NUM_FWD];
  logic              f_ready [NUM_FWD];
  logic [DATA_W-1:0] f_data  [NUM_FWD];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign bus.src_addr[i*REG_AW +: REG_AW]  = s_addr[i];
    assign bus.src_used[i]                   = s_used[i];
    assign bus.src_rdata[i*DATA_W +: DATA_W] = s_rdata[i];
  end
  for (genvar j = 0; j < NUM_FWD; j++) begin : g_fwd
    assign bus.fwd_wen[j]                   = f_wen[j];
    assign bus.fwd_addr[j*REG_AW +: REG_AW] = f_addr[j];
    assign bus.fwd_ready[j]                 = f_ready[j];
    assign bus.fwd_data[j*DATA_W +: DATA_W] = f_data[j];
  end

  int errors = 0;
  int checks = 0;

  bit                pend [2**REG_AW];
  int                cnt = 0;
  logic [DATA_W-1:0] exp_data [NUM_SRC];
  bit                exp_stall;

  function automatic bit model_busy();
    foreach (pend[r]) if (pend[r]) return 1'b1;
    return 1'b0;
  endfunction

  // Operand value and stall as the pipeline rules define them for the current inputs.
  function automatic void model_eval();
    exp_stall = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      exp_data[i] = s_rdata[i];
      if (s_used[i] && s_addr[i] != 0) begin
        for (int j = 0; j < NUM_FWD; j++) begin
          if (f_wen[j] && f_addr[j] == s_addr[i]) begin
            exp_data[i] = f_data[j];
            if (!f_ready[j]) exp_stall = 1'b1;
            break;
          end
        end
        if (pend[s_addr[i]] && !(bus.cmpl_valid && bus.cmpl_dest == s_addr[i]))
          exp_stall = 1'b1;
      end
    end
  endfunction

  task automatic tick();
    model_eval();
    if (!resetn) begin
      foreach (pend[r]) pend[r] = 1'b0;
      cnt = 0;
    end else begin
      if (exp_stall && cnt < CNT_MAX) cnt++;
      if (bus.flush) begin
        foreach (pend[r]) pend[r] = 1'b0;
      end else begin
        if (bus.cmpl_valid) pend[bus.cmpl_dest] = 1'b0;
        if (bus.issue_valid && !exp_stall && bus.issue_long && bus.issue_dest != 0)
          pend[bus.issue_dest] = 1'b1;
      end
    end
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    for (int i = 0; i < NUM_SRC; i++) begin
      s_addr[i] = '0; s_used[i] = 1'b0; s_rdata[i] = '0;
    end
    for (int j = 0; j < NUM_FWD; j++) begin
      f_wen[j] = 1'b0; f_addr[j] = '0; f_ready[j] = 1'b0; f_data[j] = '0;
    end
    bus.issue_valid = 1'b0; bus.issue_long = 1'b0; bus.issue_dest = '0;
    bus.cmpl_valid  = 1'b0; bus.cmpl_dest  = '0;  bus.flush      = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    idle();
    tick();
    tick();
    resetn = 1'b1;
    #1;
    checks++;
    if (bus.sb_busy !== 1'b0) begin errors++; $display("FAIL reset_sb_busy got=%b exp=0", bus.sb_busy); end
    checks++;
    if (bus.stall_cnt !== '0) begin errors++; $display("FAIL reset_stall_cnt got=%0d exp=0", bus.stall_cnt); end
    checks++;
    if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", bus.stall); end
  endtask

  task automatic test_fwd_priority();
    idle();
    f_wen[0] = 1; f_addr[0] = 8; f_ready[0] = 1; f_data[0] = 32'hAAAA;
    f_wen[1] = 1; f_addr[1] = 8; f_ready[1] = 1; f_data[1] = 32'hBBBB;
    s_addr[0] = 8; s_used[0] = 1; s_rdata[0] = 32'hDEAD;
    #1;
    checks++;
    if (bus.src_data[0 +: DATA_W] !== 32'hAAAA) begin
      errors++; $display("FAIL fwd_prio_data0 got=%h exp=0000aaaa", bus.src_data[0 +: DATA_W]);
    end
    checks++;
    if (bus.stall !== 1'b0) begin errors++; $display("FAIL fwd_prio_stall got=%b exp=0", bus.stall); end
    tick();
  endtask

  task automatic test_load_use();
    idle();
    f_wen[0] = 1; f_addr[0] = 9; f_ready[0] = 0; f_data[0] = 32'h1111;
    f_wen[1] = 1; f_addr[1] = 9; f_ready[1] = 1; f_data[1] = 32'h5555;
    s_addr[1] = 9; s_used[1] = 1; s_rdata[1] = 32'h7777;
    #1;
    checks++;
    if (bus.stall !== 1'b1) begin errors++; $display("FAIL load_use_stall got=%b exp=1", bus.stall); end
    tick();
    s_used[1] = 0;
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin errors++; $display("FAIL load_use_unused_stall got=%b exp=0", bus.stall); end
    checks++;
    if (bus.src_data[DATA_W +: DATA_W] !== 32'h7777) begin
      errors++; $display("FAIL load_use_unused_data1 got=%h exp=00007777", bus.src_data[DATA_W +: DATA_W]);
    end
    tick();
  endtask

  task automatic test_scoreboard();
    idle();
    bus.issue_valid = 1; bus.issue_long = 1; bus.issue_dest = 5;
    tick();
    idle();
    s_addr[0] = 5; s_used[0] = 1;
    #1;
    checks++;
    if (bus.stall !== 1'b1) begin errors++; $display("FAIL sb_pending_stall got=%b exp=1", bus.stall); end
    checks++;
    if (bus.sb_busy !== 1'b1) begin errors++; $display("FAIL sb_pending_busy got=%b exp=1", bus.sb_busy); end
    tick();
    bus.cmpl_valid = 1; bus.cmpl_dest = 5;
    f_wen[2] = 1; f_addr[2] = 5; f_ready[2] = 1; f_data[2] = 32'h1234;
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin errors++; $display("FAIL sb_cmpl_stall got=%b exp=0", bus.stall); end
    checks++;
    if (bus.src_data[0 +: DATA_W] !== 32'h1234) begin
      errors++; $display("FAIL sb_cmpl_data0 got=%h exp=00001234", bus.src_data[0 +: DATA_W]);
    end
    tick();
    idle();
    #1;
    checks++;
    if (bus.sb_busy !== 1'b0) begin errors++; $display("FAIL sb_cleared_busy got=%b exp=0", bus.sb_busy); end
  endtask

  task automatic test_set_over_clear();
    idle();
    bus.issue_valid = 1; bus.issue_long = 1; bus.issue_dest = 5;
    tick();
    bus.cmpl_valid = 1; bus.cmpl_dest = 5;
    tick();
    idle();
    s_addr[0] = 5; s_used[0] = 1;
    #1;
    checks++;
    if (bus.stall !== 1'b1) begin errors++; $display("FAIL set_over_clear_stall got=%b exp=1", bus.stall); end
    checks++;
    if (bus.sb_busy !== 1'b1) begin errors++; $display("FAIL set_over_clear_busy got=%b exp=1", bus.sb_busy); end
    idle();
    bus.cmpl_valid = 1; bus.cmpl_dest = 5;
    tick();
  endtask

  task automatic test_flush();
    idle();
    bus.issue_valid = 1; bus.issue_long = 1; bus.issue_dest = 3;
    tick();
    bus.issue_dest = 7;
    tick();
    bus.issue_dest = 4; bus.flush = 1;
    tick();
    idle();
    s_addr[0] = 3; s_used[0] = 1; s_addr[1] = 7; s_used[1] = 1;
    #1;
    checks++;
    if (bus.sb_busy !== 1'b0) begin errors++; $display("FAIL flush_busy got=%b exp=0", bus.sb_busy); end
    checks++;
    if (bus.stall !== 1'b0) begin errors++; $display("FAIL flush_stall_3_7 got=%b exp=0", bus.stall); end
    tick();
    s_addr[0] = 4;
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin errors++; $display("FAIL flush_stall_4 got=%b exp=0", bus.stall); end
    tick();
  endtask

  task automatic test_saturation();
    idle();
    f_wen[0] = 1; f_addr[0] = 9; f_ready[0] = 0;
    s_addr[0] = 9; s_used[0] = 1;
    for (int k = 0; k < 20; k++) tick();
    #1;
    checks++;
    if (bus.stall_cnt !== CNT_W'(CNT_MAX)) begin
      errors++; $display("FAIL sat_cnt got=%0d exp=%0d", bus.stall_cnt, CNT_MAX);
    end
    tick();
    checks++;
    if (bus.stall_cnt !== CNT_W'(CNT_MAX)) begin
      errors++; $display("FAIL sat_hold got=%0d exp=%0d", bus.stall_cnt, CNT_MAX);
    end
    idle();
    bus.issue_valid = 1; bus.issue_long = 1; bus.issue_dest = 6;
    tick();
    idle();
    resetn = 0;
    tick();
    resetn = 1;
    #1;
    checks++;
    if (bus.stall_cnt !== '0) begin errors++; $display("FAIL midreset_cnt got=%0d exp=0", bus.stall_cnt); end
    checks++;
    if (bus.sb_busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got=%b exp=0", bus.sb_busy); end
    bus.issue_valid = 1; bus.issue_long = 1; bus.issue_dest = 0;
    tick();
    idle();
    f_wen[0] = 1; f_addr[0] = 0; f_ready[0] = 0;
    s_addr[0] = 0; s_used[0] = 1; s_addr[1] = 0; s_used[1] = 1;
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin errors++; $display("FAIL zero_reg_stall got=%b exp=0", bus.stall); end
    checks++;
    if (bus.sb_busy !== 1'b0) begin errors++; $display("FAIL zero_reg_busy got=%b exp=0", bus.sb_busy); end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      resetn = ($urandom_range(0, 59) != 0);
      for (int i = 0; i < NUM_SRC; i++) begin
        s_addr[i]  = REG_AW'($urandom_range(0, 7));
        s_used[i]  = $urandom_range(0, 3) != 0;
        s_rdata[i] = $urandom;
      end
      for (int j = 0; j < NUM_FWD; j++) begin
        f_wen[j]   = $urandom_range(0, 1) != 0;
        f_addr[j]  = REG_AW'($urandom_range(0, 7));
        f_ready[j] = $urandom_range(0, 3) != 0;
        f_data[j]  = $urandom;
      end
      bus.issue_valid = $urandom_range(0, 1) != 0;
      bus.issue_long  = $urandom_range(0, 1) != 0;
      bus.issue_dest  = REG_AW'($urandom_range(0, 7));
      bus.cmpl_valid  = $urandom_range(0, 2) == 0;
      bus.cmpl_dest   = REG_AW'($urandom_range(0, 7));
      bus.flush       = $urandom_range(0, 24) == 0;
      #1;
      model_eval();
      for (int i = 0; i < NUM_SRC; i++) begin
        checks++;
        if (bus.src_data[i*DATA_W +: DATA_W] !== exp_data[i]) begin
          errors++;
          $display("FAIL rand_data%0d cyc=%0d got=%h exp=%h", i, n, bus.src_data[i*DATA_W +: DATA_W], exp_data[i]);
        end
      end
      checks++;
      if (bus.stall !== exp_stall) begin
        errors++; $display("FAIL rand_stall cyc=%0d got=%b exp=%b", n, bus.stall, exp_stall);
      end
      checks++;
      if (bus.sb_busy !== model_busy()) begin
        errors++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", n, bus.sb_busy, model_busy());
      end
      checks++;
      if (bus.stall_cnt !== CNT_W'(cnt)) begin
        errors++; $display("FAIL rand_cnt cyc=%0d got=%0d exp=%0d", n, bus.stall_cnt, cnt);
      end
      tick();
    end
    resetn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fwd_priority();
    test_load_use();
    test_scoreboard();
    test_set_over_clear();
    test_flush();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
